// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Stall/flush controller for the 5-stage MIPS core. Lives in ID next to the
// forwarding unit and drives the PC, IF/ID and ID/EX register enables.
//
// It handles the hazards that forwarding cannot cover:
//   - load-use: one bubble while the load is still in EX
//   - mult/div busy: mfhi/mflo or a new mult/div is held in ID until the
//     counted latency expires
//   - taken branch resolved in ID: IF/ID is flushed
//
// Optional feature macro: HAZARD_STATS_EN adds a 32-bit stall_count_o
// register counting every stalled cycle. It wraps from 0xFFFFFFFF to 0.
//
// Parameter constraints: MD_LATENCY in 1..15 and 2**CNT_W > MD_LATENCY.

`ifndef R_WIDTH
`define R_WIDTH [4:0]
`endif

module hazard_control_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic `R_WIDTH ID_rs_i,
  input  logic `R_WIDTH ID_rt_i,
  input  logic         ID_uses_rt_i,
  input  logic         ID_md_start_i,
  input  logic         ID_reads_hilo_i,
  input  logic         ID_branch_taken_i,
  input  logic `R_WIDTH EX_rd_i,
  input  logic         EX_mem_read_i,
  output logic         pc_write_o,
  output logic         IFID_write_o,
  output logic         IFID_flush_o,
  output logic         IDEX_bubble_o,
  output logic         md_busy_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_count_o
`endif
);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] busy_cnt, busy_cnt_nx;
  logic             load_use, md_stall, stall;
  logic             cnt_nz;

  // Hazard detection: purely combinational from ID/EX fields and busy_cnt.
  // A load to r0 never creates a dependency because r0 is hardwired.
  always_comb begin
    cnt_nz   = (busy_cnt != '0);
    load_use = EX_mem_read_i && (EX_rd_i != '0) &&
               ((ID_rs_i == EX_rd_i) || (ID_uses_rt_i && (ID_rt_i == EX_rd_i)));
    md_stall = cnt_nz && (ID_reads_hilo_i || ID_md_start_i);
    stall    = load_use || md_stall;
  end

  // State register: reset aborts any count in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_nx;
      busy_cnt <= busy_cnt_nx;
    end
  end

  // Next-state logic: a mult/div is accepted only when not stalled; the count
  // runs down every cycle regardless of stalls and never wraps below zero.
  always_comb begin
    state_nx    = state;
    busy_cnt_nx = busy_cnt;
    case (state)
      IDLE: begin
        if (ID_md_start_i && !stall) begin
          state_nx    = MD_BUSY;
          busy_cnt_nx = LAT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_nz)
          busy_cnt_nx = busy_cnt - CNT_ONE;
        if ((busy_cnt == CNT_ONE) || !cnt_nz)
          state_nx = IDLE;
      end
      default: begin
        state_nx    = IDLE;
        busy_cnt_nx = '0;
      end
    endcase
  end

  // Output logic: zero-latency enables. A stall freezes PC and IF/ID, bubbles
  // ID/EX and suppresses any branch flush; the branch is re-evaluated once the
  // stall clears because IF/ID still holds it.
  always_comb begin
    pc_write_o    = !stall;
    IFID_write_o  = !stall;
    IDEX_bubble_o = stall;
    IFID_flush_o  = !stall && ID_branch_taken_i;
    md_busy_o     = cnt_nz;
  end

`ifdef HAZARD_STATS_EN
  // Stall statistics: one increment per stalled cycle, natural wrap at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_count_o <= '0;
    else if (stall)
      stall_count_o <= stall_count_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
// Table-driven check of hazard_control_unit with default parameters
// (MD_LATENCY = 4). Each record is one clock cycle of stimulus plus the
// expected combinational outputs for that cycle; records are applied in order
// so multi-cycle behaviour (busy count, reset abort) is encoded in the table.
// Expected records go through a scoreboard queue: pushed when driven, popped
// and compared at the falling edge. Build with HAZARD_STATS_EN defined to also
// check the stall counter.

module tb_hazard_control_unit;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       md;
    logic       hilo;
    logic       br;
    logic [4:0] exrd;
    logic       exmr;
    logic       e_stall;
    logic       e_flush;
    logic       e_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] ID_rs_i = '0, ID_rt_i = '0, EX_rd_i = '0;
  logic       ID_uses_rt_i = 1'b0, ID_md_start_i = 1'b0, ID_reads_hilo_i = 1'b0;
  logic       ID_branch_taken_i = 1'b0, EX_mem_read_i = 1'b0;
  logic       pc_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, md_busy_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int row   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ID_rs_i          (ID_rs_i),
    .ID_rt_i          (ID_rt_i),
    .ID_uses_rt_i     (ID_uses_rt_i),
    .ID_md_start_i    (ID_md_start_i),
    .ID_reads_hilo_i  (ID_reads_hilo_i),
    .ID_branch_taken_i(ID_branch_taken_i),
    .EX_rd_i          (EX_rd_i),
    .EX_mem_read_i    (EX_mem_read_i),
    .pc_write_o       (pc_write_o),
    .IFID_write_o     (IFID_write_o),
    .IFID_flush_o     (IFID_flush_o),
    .IDEX_bubble_o    (IDEX_bubble_o),
    .md_busy_o        (md_busy_o)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count_o    (stall_count_o)
`endif
  );

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic md, input logic hilo,
                              input logic br, input logic [4:0] exrd, input logic exmr,
                              input logic e_stall, input logic e_flush, input logic e_busy);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.md = md; v.hilo = hilo;
    v.br = br; v.exrd = exrd; v.exmr = exmr;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic cmp1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL row%0d %s: got %b want %b", row, name, got, want);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst_i = v.rst; ID_rs_i = v.rs; ID_rt_i = v.rt; ID_uses_rt_i = v.uses_rt;
    ID_md_start_i = v.md; ID_reads_hilo_i = v.hilo; ID_branch_taken_i = v.br;
    EX_rd_i = v.exrd; EX_mem_read_i = v.exmr;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    cmp1("pc_write",    pc_write_o,    !e.e_stall);
    cmp1("IFID_write",  IFID_write_o,  !e.e_stall);
    cmp1("IDEX_bubble", IDEX_bubble_o, e.e_stall);
    cmp1("IFID_flush",  IFID_flush_o,  e.e_flush);
    cmp1("md_busy",     md_busy_o,     e.e_busy);
    row++;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //               rst rs  rt uses md hilo br exrd exmr | stall flush busy
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0)); // post-reset idle
    tbl.push_back(mk(0, 8,  0, 0, 0, 0, 0, 8, 1,  1, 0, 0)); // load-use on rs
    tbl.push_back(mk(0, 8,  0, 0, 0, 0, 0, 8, 0,  0, 0, 0)); // bubble in EX, released
    tbl.push_back(mk(0, 0,  0, 0, 0, 0, 0, 0, 1,  0, 0, 0)); // load to r0
    tbl.push_back(mk(0, 1,  9, 0, 0, 0, 0, 9, 1,  0, 0, 0)); // rt match, rt not used
    tbl.push_back(mk(0, 1,  9, 1, 0, 0, 0, 9, 1,  1, 0, 0)); // rt match, rt used
    tbl.push_back(mk(0, 1,  2, 1, 0, 0, 1, 9, 0,  0, 1, 0)); // taken branch, no hazard
    tbl.push_back(mk(0, 8,  0, 0, 0, 0, 1, 8, 1,  1, 0, 0)); // branch + load-use
    tbl.push_back(mk(0, 8,  0, 0, 1, 0, 0, 8, 1,  1, 0, 0)); // md_start + load-use: rejected
    tbl.push_back(mk(0, 1,  2, 0, 1, 0, 0, 0, 0,  0, 0, 0)); // mult accepted (t)
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  1, 0, 1)); // mfhi t+1
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  1, 0, 1)); // t+2
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  1, 0, 1)); // t+3
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  1, 0, 1)); // t+4
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  0, 0, 0)); // t+5 mfhi proceeds
    tbl.push_back(mk(0, 1,  2, 0, 1, 0, 1, 0, 0,  0, 1, 0)); // div accepted + branch flush
    tbl.push_back(mk(0, 1,  2, 0, 1, 0, 1, 0, 0,  1, 0, 1)); // new div held, branch ignored
    tbl.push_back(mk(0, 1,  2, 0, 0, 0, 0, 0, 0,  0, 0, 1)); // busy, no hazard
    tbl.push_back(mk(1, 1,  2, 0, 0, 0, 0, 0, 0,  0, 0, 1)); // reset mid-busy
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  0, 0, 0)); // count aborted, mfhi free
    tbl.push_back(mk(0, 1,  2, 0, 1, 0, 0, 0, 0,  0, 0, 0)); // mult accepted
    tbl.push_back(mk(0, 3,  2, 0, 0, 0, 0, 3, 1,  1, 0, 1)); // load-use while busy
    tbl.push_back(mk(1, 1,  2, 0, 0, 0, 0, 0, 0,  0, 0, 1)); // reset in cycle 2 of count
    tbl.push_back(mk(0, 1,  2, 0, 0, 1, 0, 0, 0,  0, 0, 0)); // mfhi not stalled

    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Hand sequence: reset, one load-use stall, then a mult followed by mfhi
    // for the whole latency; five stalled cycles in total.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    apply(mk(0, 5, 0, 0, 0, 0, 0, 5, 1,  1, 0, 0));
    apply(mk(0, 5, 0, 0, 1, 0, 0, 5, 0,  0, 0, 0));
    for (int k = 0; k < 4; k++)
      apply(mk(0, 5, 0, 0, 0, 1, 0, 0, 0,  1, 0, 1));
    apply(mk(0, 5, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0));
`ifdef HAZARD_STATS_EN
    n_cmp++;
    if (stall_count_o !== 32'd5) begin
      n_bad++;
      $display("FAIL stall_count: got %0d want 5", stall_count_o);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
